arb_mux: RTL and testbench

Parametrised N-channel, W-bit registered arbitrating multiplexer. It replaces fixed-select mux trees wherever several producers share one datapath, for example writeback sources or memory requesters. Each cycle it picks one valid input channel under fixed-priority or round-robin policy and captures that channel's data into a one-entry output register. It uses a valid/ready handshake on every input and on the output.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_mux_rr_pick.sv | 37 +++
 rtl/arb_mux.sv | 77 +++++++
 tb/tb_arb_mux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer slice.
package arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of a channel index; a single channel still gets a 1-bit field.
   function automatic int sel_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotate / priority-encode / unrotate picker: first set request at or above base, wrapping.
module rr_pick #(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    base,
   output logic [SEL_W-1:0]    win,
   output logic                any
);

   logic [2*CHANNELS-1:0] dbl;
   logic [2*CHANNELS-1:0] shifted;
   logic [CHANNELS-1:0]   rot;
   logic [SEL_W-1:0]      off;
   logic [SEL_W:0]        sum;

   // Doubling the vector makes the right shift behave as a rotation.
   assign dbl     = {req, req};
   assign shifted = dbl >> base;
   assign rot     = shifted[CHANNELS-1:0];
   assign any     = |req;

   always_comb begin
      off = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (rot[k]) off = SEL_W'(k);
      end
   end

   always_comb begin
      sum = {1'b0, base} + {1'b0, off};
      if (sum >= (SEL_W + 1)'(CHANNELS)) sum = sum - (SEL_W + 1)'(CHANNELS);
      win = sum[SEL_W-1:0];
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered arbitrating multiplexer with valid/ready on every port.
module arb_mux
   import arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = sel_w(CHANNELS),
   parameter int MODE     = ARB_RR
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
);

   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [SEL_W-1:0] out_sel_reg;
   logic [SEL_W-1:0] rr_ptr_reg;
   logic [SEL_W-1:0] win;
   logic             any;
   logic             can_load;
   logic             load;

   assign can_load = !out_valid_reg | out_ready;
   assign load     = can_load & any & !reset;

   rr_pick #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) u_pick (
      .req  (in_valid),
      .base (rr_ptr_reg),
      .win  (win),
      .any  (any)
   );

   assign in_ready = load ? (CHANNELS'(1) << win) : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sel_reg   <= '0;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= in_data[int'(win)*WIDTH +: WIDTH];
         out_sel_reg   <= win;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Fixed priority never rotates, so the pointer collapses to a constant zero base.
   generate
      if (MODE == ARB_RR) begin : g_rr
         always_ff @(posedge clock) begin
            if (reset)
               rr_ptr_reg <= '0;
            else if (load)
               rr_ptr_reg <= (win == SEL_W'(CHANNELS - 1)) ? '0 : win + 1'b1;
         end
      end else begin : g_fixed
         assign rr_ptr_reg = '0;
      end
   endgenerate

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Drives three arb_mux instances (8ch round-robin, 8ch fixed, 5ch round-robin) against a queue-free reference model.
module tb_arb_mux;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_valid;
   logic [255:0] in_data;
   logic         out_ready;

   logic [7:0]  ir_rr, ir_fx;
   logic [4:0]  ir_np;
   logic        ov_rr, ov_fx, ov_np;
   logic [31:0] od_rr, od_fx, od_np;
   logic [2:0]  os_rr, os_fx, os_np;

   int tests = 0;
   int fails = 0;

   // reference model state per instance: 0 = rr8, 1 = fixed8, 2 = rr5
   int          chans [3] = '{8, 8, 5};
   int          modes [3] = '{1, 0, 1};
   logic        m_valid [3];
   logic [31:0] m_data [3];
   int          m_sel [3];
   int          m_ptr [3];

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(32), .CHANNELS(8), .MODE(1)) u_rr (
      .clock(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
      .out_ready(out_ready));

   arb_mux #(.WIDTH(32), .CHANNELS(8), .MODE(0)) u_fx (
      .clock(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir_fx), .out_valid(ov_fx), .out_data(od_fx), .out_sel(os_fx),
      .out_ready(out_ready));

   arb_mux #(.WIDTH(32), .CHANNELS(5), .MODE(1)) u_np (
      .clock(clk), .reset(reset), .in_valid(in_valid[4:0]), .in_data(in_data[159:0]),
      .in_ready(ir_np), .out_valid(ov_np), .out_data(od_np), .out_sel(os_np),
      .out_ready(out_ready));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Channel that should win: first valid one searched from the start point, wrapping modulo n.
   function automatic int pick(input int i, input logic [7:0] v);
      int n = chans[i];
      int start = (modes[i] == 1) ? m_ptr[i] : 0;
      for (int off = 0; off < n; off++) begin
         if (v[(start + off) % n]) return (start + off) % n;
      end
      return -1;
   endfunction

   function automatic logic [7:0] exp_ready(input int i);
      int w = pick(i, in_valid);
      if (reset || !(!m_valid[i] || out_ready) || w < 0) return 8'h00;
      return 8'h01 << w;
   endfunction

   function automatic logic [7:0] get_ir(input int i);
      case (i)
         0: return ir_rr;
         1: return ir_fx;
         default: return {3'b000, ir_np};
      endcase
   endfunction

   function automatic logic get_ov(input int i);
      case (i)
         0: return ov_rr;
         1: return ov_fx;
         default: return ov_np;
      endcase
   endfunction

   function automatic logic [31:0] get_od(input int i);
      case (i)
         0: return od_rr;
         1: return od_fx;
         default: return od_np;
      endcase
   endfunction

   function automatic logic [2:0] get_os(input int i);
      case (i)
         0: return os_rr;
         1: return os_fx;
         default: return os_np;
      endcase
   endfunction

   // One cycle: apply inputs after a negedge, check in_ready, clock, then check registered outputs.
   task automatic step(input logic r, input logic [7:0] v, input logic rdy);
      int w [3];
      logic can [3];
      reset = r;
      in_valid = v;
      out_ready = rdy;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("i%0d_in_ready", i), {56'd0, get_ir(i)}, {56'd0, exp_ready(i)});
         w[i] = pick(i, v);
         can[i] = !m_valid[i] || rdy;
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_sel[i] = 0; m_ptr[i] = 0;
         end else if (can[i] && w[i] >= 0) begin
            m_valid[i] = 1'b1;
            m_data[i] = in_data[w[i]*32 +: 32];
            m_sel[i] = w[i];
            if (modes[i] == 1) m_ptr[i] = (w[i] + 1) % chans[i];
         end else if (rdy) begin
            m_valid[i] = 1'b0;
         end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("i%0d_out_valid", i), {63'd0, get_ov(i)}, {63'd0, m_valid[i]});
         check($sformatf("i%0d_out_data", i), {32'd0, get_od(i)}, {32'd0, m_data[i]});
         check($sformatf("i%0d_out_sel", i), {61'd0, get_os(i)}, 64'(m_sel[i]));
      end
      $display("[TB] t=%0t rst=%0b v=%02h rdy=%0b sel=%0d/%0d/%0d", $time, r, v, rdy,
               os_rr, os_fx, os_np);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_valid[i] = 1'b0; m_data[i] = '0; m_sel[i] = 0; m_ptr[i] = 0;
      end
      for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = 32'hA0 + k;
      reset = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      @(negedge clk);

      // reset held two cycles with every channel requesting
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      check("reset_out_valid", {63'd0, ov_rr}, 64'd0);
      check("reset_out_data", {32'd0, od_fx}, 64'd0);

      // fixed priority picks channel 2 of 8'b1010_0100
      for (int c = 0; c < 4; c++) step(1'b0, 8'hA4, 1'b1);
      check("fixed_data", {32'd0, od_fx}, 64'hA2);
      check("fixed_sel", {61'd0, os_fx}, 64'd2);

      // round-robin sweep from a fresh pointer
      step(1'b1, 8'h00, 1'b1);
      for (int c = 0; c < 9; c++) begin
         step(1'b0, 8'hFF, 1'b1);
         check("rr_seq", {61'd0, os_rr}, 64'(c % 8));
         check("np_seq", {61'd0, os_np}, 64'(c % 5));
      end

      // bring the pointer to 5, then only channel 0 requests: must wrap
      step(1'b0, 8'h10, 1'b1);
      step(1'b0, 8'h01, 1'b1);
      check("rr_wrap", {61'd0, os_rr}, 64'd0);

      // backpressure with the output full, then drain and load together
      step(1'b0, 8'hFF, 1'b1);
      for (int c = 0; c < 3; c++) step(1'b0, 8'hFF, 1'b0);
      step(1'b0, 8'hFF, 1'b1);

      // idle drain
      step(1'b0, 8'h00, 1'b1);
      check("idle_drain", {63'd0, ov_rr}, 64'd0);
      step(1'b0, 8'hFF, 1'b1);

      // random traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
         step($urandom_range(0, 60) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
